// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the serial subtractor: FSM state encoding and the slice-counter width.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        SERSUB_IDLE = 2'd0,
        SERSUB_RUN  = 2'd1,
        SERSUB_DONE = 2'd2
    } sersub_state_t;

    // A single-slice configuration still needs a one-bit counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// One-bit full subtractor cell: d = x - y - bi, bo is the borrow out of this bit.
module fs_cell (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor diff = a - b - bin, SLICE bits per cycle, LSB slice first.
// Define SERSUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SLICE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    sersub_state_t    state;
    sersub_state_t    state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             borrow;
    logic [SLICE:0]   chain;
    logic [SLICE-1:0] slice_d;
    logic             accept;
    logic             last;

    // The current slice always sits in the low bits of the operand shift registers.
    assign chain[0] = borrow;

    generate
        for (genvar i = 0; i < SLICE; i++) begin : g_cell
            fs_cell u_cell (
                .x  (a_sh[i]),
                .y  (b_sh[i]),
                .bi (chain[i]),
                .d  (slice_d[i]),
                .bo (chain[i+1])
            );
        end
    endgenerate

    assign accept = in_valid && in_ready;
    assign last   = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SERSUB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            SERSUB_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = SERSUB_RUN;
                end
            end
            SERSUB_RUN: begin
                if (last) begin
                    state_nxt = SERSUB_DONE;
                end
            end
            SERSUB_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = SERSUB_IDLE;
                end
            end
            default: state_nxt = SERSUB_IDLE;
        endcase
    end

    // Outputs are not cleared on accept; RUN overwrites diff slice by slice.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            borrow <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
`ifdef SERSUB_OVF_EN
            ovf    <= 1'b0;
`endif
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            borrow <= bin;
            cnt    <= '0;
        end else if (state == SERSUB_RUN) begin
            diff[cnt*SLICE +: SLICE] <= slice_d;
            a_sh   <= a_sh >> SLICE;
            b_sh   <= b_sh >> SLICE;
            borrow <= chain[SLICE];
            cnt    <= cnt + 1'b1;
            if (last) begin
                bout <= chain[SLICE];
`ifdef SERSUB_OVF_EN
                ovf  <= chain[SLICE-1] ^ chain[SLICE];
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (SLICE=1 and SLICE=4 instances) and fs_cell.
module tb_serial_subtractor;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] diff;
        logic       bout;
        logic       ovf;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       in_valid;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] diff;
    logic       bout;
    logic       in_valid4;
    logic       in_ready4;
    logic       out_valid4;
    logic       out_ready4;
    logic [7:0] diff4;
    logic       bout4;
`ifdef SERSUB_OVF_EN
    logic       ovf;
    logic       ovf4;
`endif
    logic       fx;
    logic       fy;
    logic       fbi;
    logic       fd;
    logic       fbo;

    int checks = 0;
    int errors = 0;
    vec_t vecs[6];

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8), .SLICE(1)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
`ifdef SERSUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    serial_subtractor #(.WIDTH(8), .SLICE(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .diff      (diff4),
        .bout      (bout4)
`ifdef SERSUB_OVF_EN
        ,
        .ovf       (ovf4)
`endif
    );

    fs_cell u_cell (
        .x  (fx),
        .y  (fy),
        .bi (fbi),
        .d  (fd),
        .bo (fbo)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic applyStimulus(input bit wide, input logic [7:0] av, input logic [7:0] bv,
                                 input logic binv);
        int guard = 0;
        while (!(wide ? in_ready4 : in_ready) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) checkOutput("idle_timeout", 32'd0, 32'd1);
        a   = av;
        b   = bv;
        bin = binv;
        if (wide) in_valid4 = 1'b1;
        else      in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        in_valid4 = 1'b0;
    endtask

    task automatic awaitResult(input bit wide, input string name, input int exp_lat,
                               input logic [7:0] exp_diff, input logic exp_bout,
                               input logic exp_ovf, input bit release_it);
        int lat = 0;
        while (!(wide ? out_valid4 : out_valid) && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({name, "_latency"}, lat, exp_lat);
        checkOutput({name, "_diff"}, wide ? diff4 : diff, exp_diff);
        checkOutput({name, "_bout"}, wide ? bout4 : bout, exp_bout);
`ifdef SERSUB_OVF_EN
        checkOutput({name, "_ovf"}, wide ? ovf4 : ovf, exp_ovf);
`else
        if (exp_ovf === 1'bx) checkOutput({name, "_ovf_x"}, 32'd0, 32'd1);
`endif
        if (release_it) begin
            if (wide) out_ready4 = 1'b1;
            else      out_ready  = 1'b1;
            @(negedge clk);
            out_ready  = 1'b0;
            out_ready4 = 1'b0;
            checkOutput({name, "_valid_drop"}, wide ? out_valid4 : out_valid, 1'b0);
            checkOutput({name, "_ready_back"}, wide ? in_ready4 : in_ready, 1'b1);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[3] = '{8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};

        rst        = 1'b1;
        a          = '0;
        b          = '0;
        bin        = 1'b0;
        in_valid   = 1'b0;
        in_valid4  = 1'b0;
        out_ready  = 1'b0;
        out_ready4 = 1'b0;
        fx = 1'b0; fy = 1'b0; fbi = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_in_ready", in_ready, 1'b1);
        checkOutput("reset_out_valid", out_valid, 1'b0);
        checkOutput("reset_diff", diff, 8'h00);
        checkOutput("reset_bout", bout, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, vecs[i].a, vecs[i].b, vecs[i].bin);
            awaitResult(1'b0, $sformatf("vec%0d", i), 8, vecs[i].diff, vecs[i].bout,
                        vecs[i].ovf, 1'b1);
        end

        // Result held in DONE with new operands offered: nothing may move.
        applyStimulus(1'b0, 8'h33, 8'h11, 1'b0);
        awaitResult(1'b0, "hold_first", 8, 8'h22, 1'b0, 1'b0, 1'b0);
        a = 8'h20; b = 8'h03; bin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput($sformatf("hold%0d_valid", i), out_valid, 1'b1);
            checkOutput($sformatf("hold%0d_in_ready", i), in_ready, 1'b0);
            checkOutput($sformatf("hold%0d_diff", i), diff, 8'h22);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("hold_release_idle", in_ready, 1'b1);
        checkOutput("hold_release_valid", out_valid, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("hold_new_accept", in_ready, 1'b0);
        awaitResult(1'b0, "hold_second", 8, 8'h1D, 1'b0, 1'b0, 1'b1);

        // Reset asserted during the third RUN cycle aborts the operation.
        applyStimulus(1'b0, 8'h05, 8'h03, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_out_valid", out_valid, 1'b0);
        checkOutput("abort_in_ready", in_ready, 1'b1);
        checkOutput("abort_diff", diff, 8'h00);
        checkOutput("abort_bout", bout, 1'b0);
        applyStimulus(1'b0, 8'h0A, 8'h0A, 1'b0);
        awaitResult(1'b0, "after_abort", 8, 8'h00, 1'b0, 1'b0, 1'b1);

        applyStimulus(1'b1, 8'h10, 8'h01, 1'b1);
        awaitResult(1'b1, "slice4", 2, 8'h0E, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h80, 8'h01, 1'b0);
        awaitResult(1'b1, "slice4_ovf", 2, 8'h7F, 1'b0, 1'b1, 1'b1);

        for (int i = 0; i < 8; i++) begin
            int dv;
            logic [2:0] combo;
            combo = 3'(i);
            {fx, fy, fbi} = combo;
            #1;
            dv = int'(fx) - int'(fy) - int'(fbi);
            checkOutput($sformatf("fs_cell%0d_d", i), fd, (dv & 1) != 0);
            checkOutput($sformatf("fs_cell%0d_bo", i), fbo, dv < 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
